mem_port_arbiter: RTL and testbench

- Responder for the pipeline's two memory ports: port A (instruction fetch, read-only) and port B (data load/store).
- Serialises both ports onto one downstream 32-bit word memory interface (pmem_*).
- Port A has a single-entry fetch buffer so a repeated fetch of the same word responds without a downstream access.
- Produces the 2-bit counter_pick_i / counter_pick_d codes consumed by the datapath hit/miss counters.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin serialiser of fetch port A and data port B onto one
// word-wide memory, with a single-entry fetch buffer that answers repeated A fetches.
module mem_port_arbiter #(
  parameter bit BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [3:0]  wmask_b,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata_b,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata,
  output logic [1:0]  counter_pick_i,
  output logic [1:0]  counter_pick_d
);
  typedef enum logic [2:0] {IDLE, MEM_A, MEM_B, RESP_A, RESP_B} state_e;
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        write_q, write_d, buf_valid_q, buf_valid_d, hit_q, hit_d, last_b_q, last_b_d;
  logic        req_b, grant_a, hit, unused_ok;
  assign req_b     = read_b | write_b;
  assign grant_a   = read_a & (~req_b | last_b_q);
  assign hit       = BUF_EN && buf_valid_q && buf_tag_q == address_a[31:2];
  assign unused_ok = ^{address_a[1:0], address_b[1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      write_q     <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      buf_data_q  <= '0;
      buf_tag_q   <= '0;
      buf_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      last_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      write_q     <= write_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      buf_data_q  <= buf_data_d;
      buf_tag_q   <= buf_tag_d;
      buf_valid_q <= buf_valid_d;
      hit_q       <= hit_d;
      last_b_q    <= last_b_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    write_d     = write_q;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    buf_data_d  = buf_data_q;
    buf_tag_d   = buf_tag_q;
    buf_valid_d = buf_valid_q;
    hit_d       = hit_q;
    last_b_d    = last_b_q;
    case (state_q)
      IDLE: begin
        if (grant_a) begin
          state_d   = hit ? RESP_A : MEM_A;
          addr_d    = {address_a[31:2], 2'b00};
          hit_d     = hit;
          rdata_a_d = hit ? buf_data_q : rdata_a_q;
        end else if (req_b) begin
          state_d = MEM_B;
          addr_d  = {address_b[31:2], 2'b00};
          wdata_d = wdata_b;
          wmask_d = wmask_b;
          write_d = write_b;
        end
      end
      MEM_A: begin
        if (pmem_resp) begin
          state_d     = RESP_A;
          rdata_a_d   = pmem_rdata;
          buf_data_d  = pmem_rdata;
          buf_tag_d   = addr_q[31:2];
          buf_valid_d = 1'b1;
        end
      end
      MEM_B: begin
        if (pmem_resp) begin
          state_d     = RESP_B;
          rdata_b_d   = write_q ? '0 : pmem_rdata;
          buf_valid_d = (write_q && addr_q[31:2] == buf_tag_q) ? 1'b0 : buf_valid_q;
        end
      end
      RESP_A: begin
        state_d  = IDLE;
        last_b_d = 1'b0;
      end
      RESP_B: begin
        state_d  = IDLE;
        last_b_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    resp_a         = state_q == RESP_A;
    resp_b         = state_q == RESP_B;
    pmem_read      = state_q == MEM_A || (state_q == MEM_B && !write_q);
    pmem_write     = state_q == MEM_B && write_q;
    counter_pick_i = state_q == RESP_A ? (hit_q ? 2'd0 : 2'd1) : 2'd2;
    counter_pick_d = state_q == RESP_B ? 2'd1 : 2'd2;
  end
  assign rdata_a      = rdata_a_q;
  assign rdata_b      = rdata_b_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_wmask   = wmask_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors against a buffered and an unbuffered arbiter,
// with the memory side driven by hand.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, rst0_n = 1'b0;
  logic        read_a = 1'b0, read_b = 1'b0, write_b = 1'b0, pmem_resp = 1'b0;
  logic [31:0] address_a = '0, address_b = '0, wdata_b = '0, pmem_rdata = '0;
  logic [3:0]  wmask_b = '0;
  logic        resp_a, resp_b, pmem_read, pmem_write;
  logic [31:0] rdata_a, rdata_b, pmem_address, pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [1:0]  counter_pick_i, counter_pick_d;
  logic        resp_a_z, resp_b_z, pmem_read_z, pmem_write_z;
  logic [31:0] rdata_a_z, rdata_b_z, pmem_address_z, pmem_wdata_z;
  logic [3:0]  pmem_wmask_z;
  logic [1:0]  counter_pick_i_z, counter_pick_d_z;
  int n_vec = 0, n_bad = 0;
  mem_port_arbiter #(.BUF_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .read_a(read_a), .address_a(address_a), .resp_a(resp_a),
    .rdata_a(rdata_a), .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b),
    .address_b(address_b), .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .counter_pick_i(counter_pick_i), .counter_pick_d(counter_pick_d)
  );
  mem_port_arbiter #(.BUF_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .read_a(read_a), .address_a(address_a), .resp_a(resp_a_z),
    .rdata_a(rdata_a_z), .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b),
    .address_b(address_b), .wdata_b(wdata_b), .resp_b(resp_b_z), .rdata_b(rdata_b_z),
    .pmem_read(pmem_read_z), .pmem_write(pmem_write_z), .pmem_address(pmem_address_z),
    .pmem_wdata(pmem_wdata_z), .pmem_wmask(pmem_wmask_z), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .counter_pick_i(counter_pick_i_z), .counter_pick_d(counter_pick_d_z)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_resp_a", resp_a, 0);
    check("rst_resp_b", resp_b, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_pick_i", counter_pick_i, 2);
    check("rst_pick_d", counter_pick_d, 2);
    step();
    rst_n = 1'b1;
    // A-only miss, then the held request hits the buffer
    read_a = 1'b1; address_a = 32'h60;
    step();
    check("t1_rd_c1", pmem_read, 1);
    check("t1_addr", pmem_address, 32'h60);
    check("t1_wr", pmem_write, 0);
    step();
    check("t1_rd_c2", pmem_read, 1);
    step();
    check("t1_rd_c3", pmem_read, 1);
    pmem_resp = 1'b1; pmem_rdata = 32'h13;
    step();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("t1_resp_a", resp_a, 1);
    check("t1_rdata_a", rdata_a, 32'h13);
    check("t1_pick_i_miss", counter_pick_i, 1);
    check("t1_rd_done", pmem_read, 0);
    step();
    check("t1_idle_resp", resp_a, 0);
    check("t1_idle_pick", counter_pick_i, 2);
    step();
    check("t1_hit_resp", resp_a, 1);
    check("t1_hit_pick", counter_pick_i, 0);
    check("t1_hit_rdata", rdata_a, 32'h13);
    check("t1_hit_nord", pmem_read, 0);
    read_a = 1'b0;
    step();
    check("t1_end", resp_a, 0);
    // contention with both strobes held, starting from last_grant=B
    rst_n = 1'b0; #1; rst_n = 1'b1;
    read_a = 1'b1; address_a = 32'h64;
    write_b = 1'b1; address_b = 32'h100; wdata_b = 32'hDEADBEEF; wmask_b = 4'hF;
    step();
    check("t2_a_first_rd", pmem_read, 1);
    check("t2_a_first_wr", pmem_write, 0);
    check("t2_a_addr", pmem_address, 32'h64);
    pmem_resp = 1'b1; pmem_rdata = 32'hAAAA5555;
    step();
    pmem_resp = 1'b0;
    check("t2_resp_a", resp_a, 1);
    check("t2_rdata_a", rdata_a, 32'hAAAA5555);
    check("t2_no_resp_b", resp_b, 0);
    step();
    step();
    check("t2_b_wr", pmem_write, 1);
    check("t2_b_rd", pmem_read, 0);
    check("t2_b_addr", pmem_address, 32'h100);
    check("t2_b_wdata", pmem_wdata, 32'hDEADBEEF);
    check("t2_b_wmask", pmem_wmask, 4'hF);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    check("t2_resp_b", resp_b, 1);
    check("t2_rdata_b", rdata_b, 0);
    check("t2_pick_d", counter_pick_d, 1);
    step();
    check("t2_idle_pick_d", counter_pick_d, 2);
    step();
    check("t2_a_again", resp_a, 1);
    check("t2_a_again_hit", counter_pick_i, 0);
    check("t2_a_again_nowr", pmem_write, 0);
    read_a = 1'b0; write_b = 1'b0;
    step();
    // B write to the buffered word invalidates it
    write_b = 1'b1; address_b = 32'h66; wdata_b = 32'h00AB0000; wmask_b = 4'h4;
    step();
    check("t3_wr", pmem_write, 1);
    check("t3_addr", pmem_address, 32'h64);
    check("t3_wmask", pmem_wmask, 4'h4);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0; write_b = 1'b0;
    check("t3_resp_b", resp_b, 1);
    step();
    read_a = 1'b1; address_a = 32'h64;
    step();
    check("t3_a_miss_rd", pmem_read, 1);
    pmem_resp = 1'b1; pmem_rdata = 32'h11;
    step();
    pmem_resp = 1'b0; read_a = 1'b0;
    check("t3_pick_i", counter_pick_i, 1);
    check("t3_rdata_a", rdata_a, 32'h11);
    step();
    // B read with unaligned address
    read_b = 1'b1; address_b = 32'hFFF3;
    step();
    check("t4_rd", pmem_read, 1);
    check("t4_addr", pmem_address, 32'hFFF0);
    pmem_resp = 1'b1; pmem_rdata = 32'h12345678;
    step();
    pmem_resp = 1'b0; read_b = 1'b0;
    check("t4_resp_b", resp_b, 1);
    check("t4_rdata_b", rdata_b, 32'h12345678);
    check("t4_pick_d", counter_pick_d, 1);
    check("t4_pick_i", counter_pick_i, 2);
    step();
    check("t4_pick_d_once", counter_pick_d, 2);
    check("t4_resp_b_once", resp_b, 0);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    check("t4_idle_ignore_a", resp_a, 0);
    check("t4_idle_ignore_b", resp_b, 0);
    // reset in the middle of a miss
    read_a = 1'b1; address_a = 32'h200;
    step();
    check("t5_rd", pmem_read, 1);
    #2;
    rst_n = 1'b0; read_a = 1'b0;
    #1;
    check("t5_rd_drop", pmem_read, 0);
    check("t5_addr_clr", pmem_address, 0);
    step();
    rst_n = 1'b1; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    check("t5_no_resp", resp_a, 0);
    check("t5_no_rd", pmem_read, 0);
    read_a = 1'b1; address_a = 32'h64;
    step();
    check("t5_miss_rd", pmem_read, 1);
    check("t5_miss_addr", pmem_address, 32'h64);
    pmem_resp = 1'b1; pmem_rdata = 32'h77;
    step();
    pmem_resp = 1'b0; read_a = 1'b0;
    check("t5_pick_i", counter_pick_i, 1);
    check("t5_rdata_a", rdata_a, 32'h77);
    step();
    // unbuffered instance: every fetch goes to memory
    rst_n = 1'b0; rst0_n = 1'b1;
    read_a = 1'b1; address_a = 32'h60;
    step();
    check("t6_rd1", pmem_read_z, 1);
    check("t6_held_rst_pick", counter_pick_i, 2);
    pmem_resp = 1'b1; pmem_rdata = 32'h13;
    step();
    pmem_resp = 1'b0;
    check("t6_resp1", resp_a_z, 1);
    check("t6_pick1", counter_pick_i_z, 1);
    check("t6_rdata1", rdata_a_z, 32'h13);
    step();
    check("t6_idle", resp_a_z, 0);
    step();
    check("t6_rd2", pmem_read_z, 1);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0; read_a = 1'b0;
    check("t6_resp2", resp_a_z, 1);
    check("t6_pick2", counter_pick_i_z, 1);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
